// File: rtl/query_issuer.sv
// query_issuer: paced query source for the DUT query port.
// Host words are buffered in a small FIFO. Once started, one single-cycle
// query strobe is issued per DUT slot: after each strobe the block waits for
// a rising edge of iSlotTick (or a tick that already arrived during the
// strobe cycle) before issuing the next word. After NUM_QUERY strobes the
// run ends in DONE with oEnd held high (NUM_QUERY == 0 runs forever).
//
// Push handshake: a word is transferred on a rising iClk edge where iPushEn
// and oPushReady are both high. oPushReady is a register derived only from
// FIFO occupancy, never from iPushEn. A push offered while oPushReady is low
// is dropped and latches oOverflow until reset.
module query_issuer #(
  parameter int BW_QUERY_DATA = 32,
  parameter int FIFO_DEPTH    = 4,
  parameter int NUM_QUERY     = 3,
  parameter int BW_CNT        = 16
) (
  input  logic                     iClk,
  input  logic                     iRsn,
  input  logic                     iStart,
  input  logic                     iPushEn,
  input  logic [BW_QUERY_DATA-1:0] iPushData,
  output logic                     oPushReady,
  output logic                     oOverflow,
  output logic                     oQueryDataEn,
  output logic [BW_QUERY_DATA-1:0] oQueryData,
  input  logic                     iSlotTick,
  output logic [BW_CNT-1:0]        oIssueCnt,
  output logic                     oBusy,
  output logic                     oEnd,
  output logic [2:0]               oState
);

  localparam int BW_PTR = $clog2(FIFO_DEPTH);
  localparam int BW_OCC = BW_PTR + 1;
  localparam logic [BW_OCC-1:0] FULL_OCC  = BW_OCC'(FIFO_DEPTH);
  localparam logic [BW_CNT-1:0] NUM_Q_CNT = BW_CNT'(NUM_QUERY);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DATA = 3'd1,
    ISSUE     = 3'd2,
    WAIT_TICK = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t state;
  state_t nextState;

  // FIFO storage and bookkeeping
  logic [BW_QUERY_DATA-1:0] rMem [FIFO_DEPTH];
  logic [BW_PTR-1:0]        rWrPtr;
  logic [BW_PTR-1:0]        rRdPtr;
  logic [BW_OCC-1:0]        rCount;
  logic [BW_OCC-1:0]        wNextCount;
  logic                     rNotEmpty;
  logic                     wPush;
  logic                     wPop;

  // Slot tick edge detection
  logic rTickD1;
  logic wTickEdge;
  logic rPending;
  logic nPending;

  // Next values of the registered outputs
  logic              nQueryDataEn;
  logic              nBusy;
  logic              nEnd;
  logic [BW_CNT-1:0] nIssueCnt;

  assign oState    = state;
  assign wTickEdge = iSlotTick & ~rTickD1;
  assign wPush     = iPushEn & oPushReady;
  // rNotEmpty lags occupancy by one cycle, so a word pushed into an empty
  // FIFO is seen by WAIT_DATA one edge after it lands. A pop is always
  // followed by at least two non-WAIT_DATA cycles, so the lag never lets
  // an empty FIFO be popped.
  assign wPop      = (state == WAIT_DATA) & rNotEmpty;
  assign wNextCount = rCount + BW_OCC'(wPush) - BW_OCC'(wPop);

  // State register
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) state <= IDLE;
    else       state <= nextState;
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE:      if (iStart) nextState = WAIT_DATA;
      WAIT_DATA: if (rNotEmpty) nextState = ISSUE;
      ISSUE:     nextState = WAIT_TICK;
      WAIT_TICK: begin
        if (wTickEdge || rPending) begin
          if ((NUM_QUERY != 0) && (oIssueCnt == NUM_Q_CNT)) nextState = DONE;
          else                                              nextState = WAIT_DATA;
        end
      end
      DONE:      if (iStart) nextState = WAIT_DATA;
      default:   nextState = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    nQueryDataEn = (nextState == ISSUE);
    nBusy        = (nextState != IDLE) && (nextState != DONE);
    nEnd         = (nextState == DONE);
    nIssueCnt    = oIssueCnt;
    nPending     = rPending;
    case (state)
      IDLE, DONE: if (iStart) nIssueCnt = '0;
      ISSUE: begin
        nIssueCnt = oIssueCnt + BW_CNT'(1);
        if (wTickEdge) nPending = 1'b1;
      end
      WAIT_TICK: if (wTickEdge || rPending) nPending = 1'b0;
      default: ;
    endcase
  end

  // Registered control outputs, tick history and pending flag
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      oQueryDataEn <= 1'b0;
      oQueryData   <= '0;
      oIssueCnt    <= '0;
      oBusy        <= 1'b0;
      oEnd         <= 1'b0;
      rTickD1      <= 1'b0;
      rPending     <= 1'b0;
    end else begin
      oQueryDataEn <= nQueryDataEn;
      oIssueCnt    <= nIssueCnt;
      oBusy        <= nBusy;
      oEnd         <= nEnd;
      rTickD1      <= iSlotTick;
      rPending     <= nPending;
      if (wPop) oQueryData <= rMem[rRdPtr];
    end
  end

  // FIFO pointers, occupancy, ready and sticky overflow
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      rWrPtr     <= '0;
      rRdPtr     <= '0;
      rCount     <= '0;
      rNotEmpty  <= 1'b0;
      oPushReady <= 1'b1;
      oOverflow  <= 1'b0;
    end else begin
      if (wPush) rWrPtr <= rWrPtr + BW_PTR'(1);
      if (wPop)  rRdPtr <= rRdPtr + BW_PTR'(1);
      rCount     <= wNextCount;
      rNotEmpty  <= (rCount != '0);
      oPushReady <= (wNextCount != FULL_OCC);
      if (iPushEn && !oPushReady) oOverflow <= 1'b1;
    end
  end

  // FIFO storage write (contents need no reset; pointers define validity)
  always_ff @(posedge iClk) begin
    if (wPush) rMem[rWrPtr] <= iPushData;
  end

endmodule

// File: tb/tb_query_issuer.sv
// Bench for query_issuer: FIFO model with expected-word queue, strobe
// monitor, tick responder and directed scenarios.
module tb_query_issuer;

  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int NQ    = 3;
  localparam int BC    = 16;

  // Clock / reset
  logic          iClk = 1'b0;
  logic          iRsn;
  logic          iStart;
  logic          iPushEn;
  logic [W-1:0]  iPushData;
  logic          iSlotTick;
  logic          oPushReady;
  logic          oOverflow;
  logic          oQueryDataEn;
  logic [W-1:0]  oQueryData;
  logic [BC-1:0] oIssueCnt;
  logic          oBusy;
  logic          oEnd;
  logic [2:0]    oState;

  always #5 iClk = ~iClk;

  query_issuer #(
    .BW_QUERY_DATA(W), .FIFO_DEPTH(DEPTH), .NUM_QUERY(NQ), .BW_CNT(BC)
  ) dut (
    .iClk(iClk), .iRsn(iRsn), .iStart(iStart), .iPushEn(iPushEn),
    .iPushData(iPushData), .oPushReady(oPushReady), .oOverflow(oOverflow),
    .oQueryDataEn(oQueryDataEn), .oQueryData(oQueryData),
    .iSlotTick(iSlotTick), .oIssueCnt(oIssueCnt), .oBusy(oBusy),
    .oEnd(oEnd), .oState(oState)
  );

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  model_occ;
  bit  model_ovf;
  int  cyc = 0;
  int  n_strobes;
  logic prev_en;
  logic prev_end;
  bit  tick_auto;
  int  tick_delay;
  int  tick_cd;
  int  last_tick_cyc;
  int  end_rise_cyc;
  int  lat;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: advance to the falling edge, then monitor strobes and drive ticks
  task automatic cycle();
    @(negedge iClk);
    cyc++;
    if (iSlotTick) iSlotTick = 1'b0;
    if (prev_en) check("strobe_width", {63'd0, oQueryDataEn}, 64'd0);
    if (oQueryDataEn) begin
      n_strobes++;
      if (model_occ > 0) model_occ--;
      if (exp_q.size() == 0) check("strobe_unexpected", {63'd0, oQueryDataEn}, 64'd0);
      else                   check("query_data", {32'd0, oQueryData}, {32'd0, exp_q.pop_front()});
      if (tick_auto) tick_cd = tick_delay;
    end
    prev_en = oQueryDataEn;
    if (oEnd && !prev_end) end_rise_cyc = cyc;
    prev_end = oEnd;
    if (tick_cd == 0) begin
      iSlotTick     = 1'b1;
      last_tick_cyc = cyc;
      tick_cd       = -1;
    end else if (tick_cd > 0) begin
      tick_cd--;
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Driver tasks
  task automatic push_word(input logic [W-1:0] d);
    iPushEn   = 1'b1;
    iPushData = d;
    if (model_occ < DEPTH) begin
      exp_q.push_back(d);
      model_occ++;
    end else begin
      model_ovf = 1'b1;
    end
    cycle();
    iPushEn = 1'b0;
  endtask

  task automatic start_run();
    iStart = 1'b1;
    cycle();
    iStart = 1'b0;
  endtask

  task automatic wait_strobe(input int max, output int l);
    l = -1;
    for (int i = 1; i <= max; i++) begin
      cycle();
      if (oQueryDataEn) begin
        l = i;
        break;
      end
    end
  endtask

  task automatic wait_end(input int max);
    for (int i = 0; i < max; i++) begin
      if (oEnd) break;
      cycle();
    end
    check("end_reached", {63'd0, oEnd}, 64'd1);
  endtask

  task automatic do_reset(input bit check_vals);
    iRsn = 1'b0; iStart = 1'b0; iPushEn = 1'b0; iPushData = '0; iSlotTick = 1'b0;
    exp_q.delete();
    model_occ = 0; model_ovf = 1'b0;
    tick_cd = -1; tick_auto = 1'b0; tick_delay = 0;
    prev_en = 1'b0; prev_end = 1'b0; n_strobes = 0;
    cycles(2);
    if (check_vals) begin
      check("rst_ready",   {63'd0, oPushReady},   64'd1);
      check("rst_ovf",     {63'd0, oOverflow},    64'd0);
      check("rst_en",      {63'd0, oQueryDataEn}, 64'd0);
      check("rst_data",    {32'd0, oQueryData},   64'd0);
      check("rst_cnt",     {48'd0, oIssueCnt},    64'd0);
      check("rst_busy",    {63'd0, oBusy},        64'd0);
      check("rst_end",     {63'd0, oEnd},         64'd0);
      check("rst_state",   {61'd0, oState},       64'd0);
    end
    iRsn = 1'b1;
  endtask

  initial begin
    // Basic run: three preloaded words, tick 20 cycles after each strobe
    do_reset(1'b1);
    push_word(32'd5);
    push_word(32'd17);
    push_word(32'd30);
    check("ready_3_words", {63'd0, oPushReady}, {63'd0, model_occ != DEPTH});
    tick_auto = 1'b1; tick_delay = 20;
    start_run();
    check("busy_after_start", {63'd0, oBusy}, 64'd1);
    wait_strobe(5, lat);
    check("first_latency", 64'(lat), 64'd1);
    wait_end(200);
    check("run1_cnt",       {48'd0, oIssueCnt}, 64'd3);
    check("run1_strobes",   64'(n_strobes), 64'd3);
    check("end_after_tick", 64'(end_rise_cyc - last_tick_cyc), 64'd1);
    check("run1_busy_done", {63'd0, oBusy}, 64'd0);
    cycles(30);
    check("run1_no_extra",  64'(n_strobes), 64'd3);
    check("run1_end_hold",  {63'd0, oEnd}, 64'd1);

    // Overflow: five back-to-back pushes into a depth-4 FIFO
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) begin
      push_word(32'hA0 + 32'(i));
      if (i == 3) check("ready_full", {63'd0, oPushReady}, 64'd0);
    end
    check("overflow_set", {63'd0, oOverflow}, {63'd0, model_ovf});
    check("ready_full2",  {63'd0, oPushReady}, 64'd0);

    // Pending tick: tick raised during the ISSUE cycle
    tick_auto = 1'b1; tick_delay = 0; n_strobes = 0;
    start_run();
    wait_strobe(5, lat);
    check("pend_first", 64'(lat), 64'd1);
    wait_strobe(10, lat);
    check("pend_spacing1", 64'(lat), 64'd3);
    wait_strobe(10, lat);
    check("pend_spacing2", 64'(lat), 64'd3);
    wait_end(20);
    check("run2_cnt",       {48'd0, oIssueCnt}, 64'd3);
    check("overflow_stays", {63'd0, oOverflow}, 64'd1);
    check("ready_after_pop", {63'd0, oPushReady}, {63'd0, model_occ != DEPTH});

    // Restart from DONE with two words left; iStart during WAIT_TICK ignored
    push_word(32'hB0);
    tick_delay = 5; n_strobes = 0;
    start_run();
    check("restart_end_clr", {63'd0, oEnd}, 64'd0);
    check("restart_cnt_clr", {48'd0, oIssueCnt}, 64'd0);
    wait_strobe(5, lat);
    check("restart_latency", 64'(lat), 64'd1);
    cycle();
    iStart = 1'b1;
    cycle();
    iStart = 1'b0;
    check("start_ignored_cnt",  {48'd0, oIssueCnt}, 64'd1);
    check("start_ignored_busy", {63'd0, oBusy}, 64'd1);
    wait_strobe(20, lat);
    check("restart_second", {63'd0, oQueryDataEn}, 64'd1);

    // Empty FIFO: strobe two cycles after a late push
    cycles(50);
    check("empty_no_strobe", 64'(n_strobes), 64'd2);
    check("empty_busy",      {63'd0, oBusy}, 64'd1);
    push_word(32'h1F);
    wait_strobe(5, lat);
    check("push_to_strobe", 64'(lat), 64'd2);
    wait_end(50);
    check("run3_cnt", {48'd0, oIssueCnt}, 64'd3);

    // Asynchronous reset during WAIT_TICK with two words buffered
    do_reset(1'b0);
    push_word(32'hC0);
    push_word(32'hC1);
    push_word(32'hC2);
    start_run();
    wait_strobe(5, lat);
    cycles(3);
    check("pre_rst_busy", {63'd0, oBusy}, 64'd1);
    #2 iRsn = 1'b0;
    #1;
    check("arst_en",    {63'd0, oQueryDataEn}, 64'd0);
    check("arst_data",  {32'd0, oQueryData},   64'd0);
    check("arst_cnt",   {48'd0, oIssueCnt},    64'd0);
    check("arst_busy",  {63'd0, oBusy},        64'd0);
    check("arst_end",   {63'd0, oEnd},         64'd0);
    check("arst_ready", {63'd0, oPushReady},   64'd1);
    check("arst_ovf",   {63'd0, oOverflow},    64'd0);
    exp_q.delete();
    model_occ = 0;
    cycle();
    iRsn = 1'b1;
    n_strobes = 0;
    start_run();
    cycles(30);
    check("arst_no_strobe", 64'(n_strobes), 64'd0);
    check("arst_waiting",   {63'd0, oBusy}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
